// File: rtl/hqc_keygen_out_streamer_pkg.sv
// ============================================================================
// hqc_keygen_out_streamer_pkg : parameter sets, sel/type codes, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package hqc_keygen_out_streamer_pkg;

  localparam int BEAT_W = 32;

  localparam logic [1:0] TYPE_X = 2'd0;
  localparam logic [1:0] TYPE_Y = 2'd1;
  localparam logic [1:0] TYPE_H = 2'd2;
  localparam logic [1:0] TYPE_S = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic int hqc_n(input logic [47:0] ps);
    if (ps == "hqc256") return 57637;
    if (ps == "hqc192") return 35851;
    return 17669;
  endfunction

  function automatic int hqc_m(input logic [47:0] ps);
    if (ps == "hqc256" || ps == "hqc192") return 16;
    return 15;
  endfunction

  function automatic int hqc_weight(input logic [47:0] ps);
    if (ps == "hqc256") return 131;
    if (ps == "hqc192") return 100;
    return 66;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hqc_keygen_out_streamer_if.sv
// ============================================================================
// hqc_keygen_out_streamer_if : control, keygen memory port and beat stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hqc_keygen_out_streamer_if
  import hqc_keygen_out_streamer_pkg::*;
#(
  parameter int MEM_WIDTH      = 128,
  parameter int OUT_ADDR_WIDTH = 8
);
  logic                      start;
  logic [1:0]                sel;
  logic                      busy;
  logic                      done;
  logic                      keygen_out_en;
  logic [1:0]                keygen_out_type;
  logic [OUT_ADDR_WIDTH-1:0] keygen_out_addr;
  logic [MEM_WIDTH-1:0]      keygen_out;
  logic                      m_valid;
  logic                      m_ready;
  logic [BEAT_W-1:0]         m_data;
  logic [3:0]                m_keep;
  logic                      m_last;

  modport master (
    input  start, sel, keygen_out, m_ready,
    output busy, done, keygen_out_en, keygen_out_type, keygen_out_addr,
           m_valid, m_data, m_keep, m_last
  );

  modport slave (
    output start, sel, keygen_out, m_ready,
    input  busy, done, keygen_out_en, keygen_out_type, keygen_out_addr,
           m_valid, m_data, m_keep, m_last
  );
endinterface

`default_nettype wire

// File: rtl/hqc_out_skid_fifo.sv
// ============================================================================
// hqc_out_skid_fifo : 2-entry word FIFO with occupancy output
// Revision: 1.0
// ============================================================================
`default_nettype none

module hqc_out_skid_fifo #(
  parameter int WIDTH = 128
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] dout,
  output logic      [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hqc_keygen_out_streamer.sv
// ============================================================================
// hqc_keygen_out_streamer : keygen result memory to 32-bit valid/ready stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module hqc_keygen_out_streamer
  import hqc_keygen_out_streamer_pkg::*;
#(
  parameter logic [47:0] parameter_set  = "hqc128",
  parameter int          N              = hqc_n(parameter_set),
  parameter int          M              = hqc_m(parameter_set),
  parameter int          WEIGHT         = hqc_weight(parameter_set),
  parameter int          MEM_WIDTH      = 128,
  parameter int          OUT_ADDR_WIDTH =
    $clog2((N + (MEM_WIDTH - N % MEM_WIDTH) % MEM_WIDTH) / MEM_WIDTH)
) (
  input wire logic clk,
  input wire logic rst,
  hqc_keygen_out_streamer_if.master bus
);

  localparam int N_B        = N + (8 - N % 8) % 8;
  localparam int N_MEM      = N + (MEM_WIDTH - N % MEM_WIDTH) % MEM_WIDTH;
  localparam int WORDS      = N_MEM / MEM_WIDTH;
  localparam int BYTES      = N_B / 8;
  localparam int BEATS_PW   = MEM_WIDTH / BEAT_W;
  localparam int LB         = BYTES - (WORDS - 1) * (MEM_WIDTH / 8);
  localparam int LAST_BEATS = (LB + 3) / 4;
  localparam int LAST_LANES = (LB - 1) % 4 + 1;
  localparam logic [3:0] LAST_KEEP = 4'(4'hF << (4 - LAST_LANES));
  localparam int MAX_READS  = (WORDS > WEIGHT) ? WORDS : WEIGHT;
  localparam int CNT_W      = $clog2(MAX_READS + 1);
  localparam int LEFT_W     = $clog2(BEATS_PW + 1);

  state_t                    state_q;
  logic                      busy_q, done_q;
  logic [1:0]                type_q;

  logic                      en_q, en_d;
  logic [OUT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      vld_q, vld_d;
  logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]          ld_cnt_q, ld_cnt_d;
  logic                      spl_valid_q, spl_valid_d;
  logic [MEM_WIDTH-1:0]      spl_word_q, spl_word_d;
  logic [LEFT_W-1:0]         spl_left_q, spl_left_d;
  logic                      spl_final_q, spl_final_d;

  logic                      dense;
  logic                      accept;
  logic [CNT_W-1:0]          total;
  logic [MEM_WIDTH-1:0]      word_fmt;
  logic [MEM_WIDTH-1:0]      fifo_dout;
  logic [1:0]                fifo_cnt, fifo_cnt_next;
  logic                      fifo_push, fifo_pop;
  logic                      hs, spl_take, bypass, credit_ok, issue, last_beat;

  assign dense  = type_q[1];
  assign accept = (state_q == ST_IDLE) && bus.start;
  assign total  = dense ? CNT_W'(WORDS) : CNT_W'(WEIGHT);

  // Words are formatted once on arrival, so the FIFO and splitter only shift.
  always_comb begin
    word_fmt = '0;
    if (dense) begin
      for (int k = 0; k < MEM_WIDTH / 8; k++) begin
        word_fmt[8*k +: 8] = bus.keygen_out[MEM_WIDTH-8*k-1 -: 8];
      end
    end else begin
      word_fmt[MEM_WIDTH-1 -: BEAT_W] = BEAT_W'(bus.keygen_out[M-1:0]);
    end
  end

  assign hs        = spl_valid_q && bus.m_ready;
  assign last_beat = spl_valid_q && spl_final_q && (spl_left_q == LEFT_W'(1));
  assign spl_take  = (!spl_valid_q || (hs && spl_left_q == LEFT_W'(1)))
                     && ((fifo_cnt != 2'd0) || vld_q);
  assign bypass    = spl_take && (fifo_cnt == 2'd0);
  assign fifo_pop  = spl_take && (fifo_cnt != 2'd0);
  assign fifo_push = vld_q && !bypass;

  // Credit counts next-cycle occupancy plus the read whose data lands next cycle,
  // so a full stall from here on still fits both returning words.
  assign fifo_cnt_next = fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
  assign credit_ok     = ({1'b0, fifo_cnt_next} + {2'b0, en_q}) < 3'd2;
  assign issue         = (state_q == ST_RUN) && (rd_cnt_q < total) && credit_ok;

  hqc_out_skid_fifo #(
    .WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (word_fmt),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      type_q  <= TYPE_X;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            type_q  <= bus.sel;
          end
        end
        ST_RUN: begin
          if (hs && last_beat) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    en_d        = 1'b0;
    addr_d      = addr_q;
    vld_d       = en_q;
    rd_cnt_d    = rd_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    spl_valid_d = spl_valid_q;
    spl_word_d  = spl_word_q;
    spl_left_d  = spl_left_q;
    spl_final_d = spl_final_q;

    if (accept) begin
      en_d     = 1'b1;
      addr_d   = '0;
      rd_cnt_d = CNT_W'(1);
      ld_cnt_d = '0;
    end else if (issue) begin
      en_d     = 1'b1;
      addr_d   = OUT_ADDR_WIDTH'(rd_cnt_q);
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end

    if (spl_take) begin
      spl_valid_d = 1'b1;
      spl_word_d  = bypass ? word_fmt : fifo_dout;
      spl_final_d = (ld_cnt_q == total - CNT_W'(1));
      ld_cnt_d    = ld_cnt_q + CNT_W'(1);
      if (!dense)           spl_left_d = LEFT_W'(1);
      else if (spl_final_d) spl_left_d = LEFT_W'(LAST_BEATS);
      else                  spl_left_d = LEFT_W'(BEATS_PW);
    end else if (hs) begin
      if (spl_left_q == LEFT_W'(1)) begin
        spl_valid_d = 1'b0;
      end else begin
        spl_word_d = spl_word_q << BEAT_W;
        spl_left_d = spl_left_q - LEFT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q        <= 1'b0;
      addr_q      <= '0;
      vld_q       <= 1'b0;
      rd_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      spl_valid_q <= 1'b0;
      spl_word_q  <= '0;
      spl_left_q  <= '0;
      spl_final_q <= 1'b0;
    end else begin
      en_q        <= en_d;
      addr_q      <= addr_d;
      vld_q       <= vld_d;
      rd_cnt_q    <= rd_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      spl_valid_q <= spl_valid_d;
      spl_word_q  <= spl_word_d;
      spl_left_q  <= spl_left_d;
      spl_final_q <= spl_final_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.keygen_out_en   = en_q;
  assign bus.keygen_out_type = type_q;
  assign bus.keygen_out_addr = addr_q;
  assign bus.m_valid         = spl_valid_q;
  assign bus.m_data          = spl_valid_q ? spl_word_q[MEM_WIDTH-1 -: BEAT_W] : '0;
  assign bus.m_last          = last_beat;
  assign bus.m_keep          = !spl_valid_q          ? 4'h0 :
                               (last_beat && dense) ? LAST_KEEP : 4'hF;

endmodule

`default_nettype wire

// File: tb/tb_hqc_keygen_out_streamer.sv
// ============================================================================
// tb_hqc_keygen_out_streamer : directed dumps of hqc128 x/y/h/s memories
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hqc_keygen_out_streamer;

  localparam int BYTES       = 2209;
  localparam int DENSE_BEATS = 553;
  localparam int WEIGHT      = 66;
  localparam int BUDGET      = 6000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hqc_keygen_out_streamer_if #(.MEM_WIDTH(128), .OUT_ADDR_WIDTH(8)) bus ();

  hqc_keygen_out_streamer #(
    .parameter_set ("hqc128")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input int t, input int a, input int b);
    return 8'((a * 7 + b * 13 + t * 59 + 3) & 255);
  endfunction

  function automatic logic [127:0] mem_word(input logic [1:0] t, input logic [7:0] a);
    logic [127:0] w;
    for (int b = 0; b < 16; b++) w[8*b +: 8] = mem_byte(int'(t), int'(a), b);
    return w;
  endfunction

  // Memory model: data one cycle after en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.keygen_out_en)
      bus.keygen_out <= mem_word(bus.keygen_out_type, bus.keygen_out_addr);
    else
      bus.keygen_out <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dense beat k carries stream bytes 4k..4k+3, first byte in the top lane.
  task automatic exp_beat(input logic [1:0] s, input int k,
                          output logic [31:0] d, output logic [3:0] kp);
    logic [127:0] w;
    d  = '0;
    kp = '0;
    if (s[1]) begin
      for (int l = 0; l < 4; l++) begin
        int n;
        n = 4 * k + l;
        if (n < BYTES) begin
          d[31-8*l -: 8] = mem_byte(int'(s), n / 16, n % 16);
          kp[3-l] = 1'b1;
        end
      end
    end else begin
      w  = mem_word(s, 8'(k));
      d  = {17'b0, w[14:0]};
      kp = 4'hF;
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_en", 32'(bus.keygen_out_en), 0);
    check("rst_type", 32'(bus.keygen_out_type), 0);
    check("rst_addr", 32'(bus.keygen_out_addr), 0);
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_data", bus.m_data, 0);
    check("rst_keep", 32'(bus.m_keep), 0);
    check("rst_last", 32'(bus.m_last), 0);
  endtask

  // mode 0: m_ready high; mode 1: m_ready 1,0,0,1 repeating.
  task automatic run_dump(input logic [1:0] s, input int mode, input int abort_at,
                          input bit poke, input bit mid_sel);
    int k, first, total;
    bit prev_stall, timed_out;
    logic [31:0] pd, ed, mask;
    logic [3:0]  pk, ek;
    logic        pl;
    total = s[1] ? DENSE_BEATS : WEIGHT;
    k = 0; first = -1; prev_stall = 0; timed_out = 1;
    pd = '0; pk = '0; pl = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sel = s; bus.m_ready = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (poke && cyc == 10) begin bus.start = 1'b1; bus.sel = ~s; end
      if (mid_sel && cyc == 30) bus.sel = ~s;
      bus.m_ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      check("busy_run", 32'(bus.busy), 1);
      check("type_run", 32'(bus.keygen_out_type), 32'(s));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 1);
        check("stall_data", bus.m_data, pd);
        check("stall_keep", 32'(bus.m_keep), 32'(pk));
        check("stall_last", 32'(bus.m_last), 32'(pl));
      end
      if (bus.m_valid && first < 0) begin
        first = cyc;
        check("first_valid_cycle", 32'(cyc), 3);
      end
      if (bus.m_valid && bus.m_ready) begin
        exp_beat(s, k, ed, ek);
        mask = {{8{ek[3]}}, {8{ek[2]}}, {8{ek[1]}}, {8{ek[0]}}};
        check("beat_data", bus.m_data & mask, ed);
        check("beat_keep", 32'(bus.m_keep), 32'(ek));
        check("beat_last", 32'(bus.m_last), 32'(k == total - 1));
        k++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      pd = bus.m_data; pk = bus.m_keep; pl = bus.m_last;
      if ((abort_at >= 0 && k == abort_at) || k == total) begin
        timed_out = 0;
        break;
      end
    end
    if (timed_out) begin
      check("dump_timeout", 32'(k), 32'(total));
    end else if (abort_at >= 0 && k == abort_at) begin
      @(posedge clk); #1;
      rst = 1'b0; bus.m_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check_reset_values();
    end else begin
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      bus.start = poke;
      check("done_pulse", 32'(bus.done), 1);
      check("busy_at_done", 32'(bus.busy), 0);
      check("valid_after_last", 32'(bus.m_valid), 0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_width", 32'(bus.done), 0);
      for (int i = 0; i < 3; i++) begin
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_read_en", 32'(bus.keygen_out_en), 0);
        check("idle_valid", 32'(bus.m_valid), 0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.sel = 2'b00;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b1;

    run_dump(2'b11, 0, -1, 1'b1, 1'b0);  // s dense, full rate, ignored starts
    run_dump(2'b10, 1, -1, 1'b0, 1'b0);  // h dense with stalls
    run_dump(2'b00, 1, -1, 1'b0, 1'b0);  // x support with stalls
    run_dump(2'b11, 0, 20, 1'b0, 1'b0);  // reset mid-dump
    run_dump(2'b11, 0, -1, 1'b0, 1'b0);  // fresh dump after reset
    run_dump(2'b01, 0, -1, 1'b0, 1'b1);  // y support, sel changes mid-dump

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
